// File: rtl/user_tlp_req_ctrl.sv
// Request front end for a PCIe TLP encoder: queues user requests, allocates
// read tags, issues one TLP at a time and tracks read completions.
module user_tlp_req_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_TAGS   = 32
) (
  input  logic         user_clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_type,
  input  logic [63:0]  req_addr,
  input  logic [127:0] req_data,
  input  logic [10:0]  req_length,
  output logic [2:0]   tx_type,
  output logic [7:0]   tx_tag,
  output logic [63:0]  tx_addr,
  output logic [127:0] tx_data,
  output logic [10:0]  tx_length,
  output logic         tx_start,
  input  logic         tx_done,
  input  logic         cpl_valid,
  input  logic [7:0]   cpl_tag,
  output logic [8:0]   rd_outstanding,
  output logic         err_unsup,
  output logic         err_spur_cpl
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0]   typ;
    logic [63:0]  addr;
    logic [127:0] data;
    logic [10:0]  len;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [NUM_TAGS-1:0]   tag_busy_q, tag_busy_d;
  logic [8:0]            rd_cnt_q, rd_cnt_d;
  logic [2:0]            tx_type_q, tx_type_d;
  logic [7:0]            tx_tag_q, tx_tag_d;
  logic [63:0]           tx_addr_q, tx_addr_d;
  logic [127:0]          tx_data_q, tx_data_d;
  logic [10:0]           tx_length_q, tx_length_d;
  logic                  tx_start_q, tx_start_d;
  logic                  err_unsup_q, err_unsup_d;
  logic                  err_spur_q, err_spur_d;

  req_t                  mem_q [FIFO_DEPTH];
  req_t                  req_in;
  req_t                  head;
  logic                  full, empty, push, pop;
  logic                  head_rd, head_wr;
  logic                  free_found;
  logic [7:0]            free_idx;
  logic                  alloc;
  logic                  rel_hit;
  logic [NUM_TAGS-1:0]   rel_vec, alloc_vec;

  assign req_in    = '{typ: req_type, addr: req_addr, data: req_data, len: req_length};
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign head      = mem_q[rd_ptr_q];
  assign head_rd   = ~head.typ[2] & ~head.typ[0];
  assign head_wr   = ~head.typ[2] &  head.typ[0];

  always_ff @(posedge user_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_in;
    end
  end

  // Scan downwards so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = NUM_TAGS; i > 0; i--) begin
      if (!tag_busy_q[i-1]) begin
        free_found = 1'b1;
        free_idx   = 8'(i - 1);
      end
    end
  end

  always_comb begin
    rel_hit = 1'b0;
    rel_vec = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (cpl_valid && (cpl_tag == 8'(i)) && tag_busy_q[i]) begin
        rel_hit    = 1'b1;
        rel_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_type_d   = tx_type_q;
    tx_tag_d    = tx_tag_q;
    tx_addr_d   = tx_addr_q;
    tx_data_d   = tx_data_q;
    tx_length_d = tx_length_q;
    tx_start_d  = 1'b0;
    err_unsup_d = 1'b0;
    pop         = 1'b0;
    alloc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_wr || (head_rd && free_found)) begin
            tx_type_d   = head.typ;
            tx_addr_d   = head.addr;
            tx_data_d   = head.data;
            tx_length_d = head.len;
            tx_tag_d    = head_rd ? free_idx : 8'h00;
            alloc       = head_rd;
            pop         = 1'b1;
            tx_start_d  = 1'b1;
            state_d     = ISSUE;
          end else if (!head_rd) begin
            pop         = 1'b1;
            err_unsup_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    alloc_vec = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      alloc_vec[i] = alloc && (free_idx == 8'(i));
    end
    // A released tag is busy, so it can never be the one allocated this cycle.
    tag_busy_d = (tag_busy_q | alloc_vec) & ~rel_vec;
    unique case ({alloc, rel_hit})
      2'b10:   rd_cnt_d = rd_cnt_q + 9'd1;
      2'b01:   rd_cnt_d = rd_cnt_q - 9'd1;
      default: rd_cnt_d = rd_cnt_q;
    endcase
    err_spur_d = cpl_valid & ~rel_hit;
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_busy_q  <= '0;
      rd_cnt_q    <= '0;
      tx_type_q   <= '0;
      tx_tag_q    <= '0;
      tx_addr_q   <= '0;
      tx_data_q   <= '0;
      tx_length_q <= '0;
      tx_start_q  <= 1'b0;
      err_unsup_q <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_busy_q  <= tag_busy_d;
      rd_cnt_q    <= rd_cnt_d;
      tx_type_q   <= tx_type_d;
      tx_tag_q    <= tx_tag_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
      tx_length_q <= tx_length_d;
      tx_start_q  <= tx_start_d;
      err_unsup_q <= err_unsup_d;
      err_spur_q  <= err_spur_d;
    end
  end

  assign tx_type        = tx_type_q;
  assign tx_tag         = tx_tag_q;
  assign tx_addr        = tx_addr_q;
  assign tx_data        = tx_data_q;
  assign tx_length      = tx_length_q;
  assign tx_start       = tx_start_q;
  assign rd_outstanding = rd_cnt_q;
  assign err_unsup      = err_unsup_q;
  assign err_spur_cpl   = err_spur_q;

endmodule

// File: tb/tb_user_tlp_req_ctrl.sv
// Directed bench for user_tlp_req_ctrl: a default instance plus a two-tag
// instance sharing request/completion inputs, each with its own encoder model.
module tb_user_tlp_req_ctrl;

  logic         user_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [2:0]   req_type = '0;
  logic [63:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic [10:0]  req_length = '0;
  logic         tx_done = 1'b0, tx_done_b = 1'b0;
  logic         cpl_valid = 1'b0;
  logic [7:0]   cpl_tag = '0;

  logic         req_ready, tx_start, err_unsup, err_spur_cpl;
  logic [2:0]   tx_type;
  logic [7:0]   tx_tag;
  logic [63:0]  tx_addr;
  logic [127:0] tx_data;
  logic [10:0]  tx_length;
  logic [8:0]   rd_outstanding;

  logic         req_ready_b, tx_start_b, err_unsup_b, err_spur_cpl_b;
  logic [2:0]   tx_type_b;
  logic [7:0]   tx_tag_b;
  logic [63:0]  tx_addr_b;
  logic [127:0] tx_data_b;
  logic [10:0]  tx_length_b;
  logic [8:0]   rd_outstanding_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit hold_done = 1'b0;
  bit pend_a = 1'b0, pend_b = 1'b0;

  typedef struct {
    logic [2:0]   typ;
    logic [7:0]   tag;
    logic [63:0]  addr;
    logic [127:0] data;
    logic [10:0]  len;
    int           c;
  } iss_t;

  iss_t q1[$];
  iss_t q2[$];
  int   done_q[$];

  user_tlp_req_ctrl dut (
    .user_clk(user_clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_data(req_data), .req_length(req_length),
    .tx_type(tx_type), .tx_tag(tx_tag), .tx_addr(tx_addr), .tx_data(tx_data),
    .tx_length(tx_length), .tx_start(tx_start), .tx_done(tx_done), .cpl_valid(cpl_valid),
    .cpl_tag(cpl_tag), .rd_outstanding(rd_outstanding), .err_unsup(err_unsup),
    .err_spur_cpl(err_spur_cpl)
  );

  user_tlp_req_ctrl #(.FIFO_DEPTH(4), .NUM_TAGS(2)) dut_b (
    .user_clk(user_clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_type(req_type), .req_addr(req_addr), .req_data(req_data), .req_length(req_length),
    .tx_type(tx_type_b), .tx_tag(tx_tag_b), .tx_addr(tx_addr_b), .tx_data(tx_data_b),
    .tx_length(tx_length_b), .tx_start(tx_start_b), .tx_done(tx_done_b), .cpl_valid(cpl_valid),
    .cpl_tag(cpl_tag), .rd_outstanding(rd_outstanding_b), .err_unsup(err_unsup_b),
    .err_spur_cpl(err_spur_cpl_b)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;

  // Encoder models: complete one cycle after the issue pulse unless held.
  always @(posedge user_clk) begin
    #1;
    tx_done   = 1'b0;
    tx_done_b = 1'b0;
    if (!reset_n) begin
      pend_a = 1'b0;
      pend_b = 1'b0;
    end else begin
      if (tx_start) pend_a = 1'b1;
      else if (pend_a && !hold_done) begin tx_done = 1'b1; pend_a = 1'b0; end
      if (tx_start_b) pend_b = 1'b1;
      else if (pend_b && !hold_done) begin tx_done_b = 1'b1; pend_b = 1'b0; end
    end
  end

  always @(negedge user_clk) begin
    if (reset_n && tx_start) q1.push_back('{tx_type, tx_tag, tx_addr, tx_data, tx_length, cyc});
    if (reset_n && tx_start_b) q2.push_back('{tx_type_b, tx_tag_b, tx_addr_b, tx_data_b, tx_length_b, cyc});
    if (reset_n && tx_done) done_q.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = 1'b0; cpl_valid = 1'b0; hold_done = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    q1.delete(); q2.delete(); done_q.delete();
  endtask

  task automatic push(input logic [2:0] t, input logic [63:0] a, input logic [127:0] d,
                      input logic [10:0] l, output bit ok);
    req_type = t; req_addr = a; req_data = d; req_length = l; req_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_q(input int which, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (((which == 1) ? q1.size() : q2.size()) >= n) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic cpl(input logic [7:0] t);
    cpl_valid = 1'b1; cpl_tag = t;
    tick();
    cpl_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(1);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%0h exp=0", tx_start); end
    total++; if (err_unsup !== 1'b0) begin bad++; $display("FAIL rst_err_unsup got=%0h exp=0", err_unsup); end
    total++; if (err_spur_cpl !== 1'b0) begin bad++; $display("FAIL rst_err_spur got=%0h exp=0", err_spur_cpl); end
    total++; if (rd_outstanding !== 9'd0) begin bad++; $display("FAIL rst_rd_out got=%0d exp=0", rd_outstanding); end
    total++; if ({tx_type, tx_tag, tx_addr, tx_data, tx_length} !== '0) begin bad++; $display("FAIL rst_tx_fields got=%0h exp=0", {tx_type, tx_tag, tx_addr, tx_data, tx_length}); end
    reset_n = 1'b1;
    tick(3);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0h exp=1", req_ready); end
    total++; if (q1.size() != 0) begin bad++; $display("FAIL rst_no_start got=%0d exp=0", q1.size()); end
  endtask

  task automatic test_write();
    bit ok;
    do_reset();
    hold_done = 1'b1;
    push(3'b001, 64'h1000, 128'hAABBCCDD, 11'd1, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_push got=timeout exp=accepted"); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL wr_early_start got=%0h exp=0", tx_start); end
    tick();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL wr_start got=%0h exp=1", tx_start); end
    total++; if (tx_type !== 3'b001) begin bad++; $display("FAIL wr_type got=%0h exp=1", tx_type); end
    total++; if (tx_tag !== 8'h00) begin bad++; $display("FAIL wr_tag got=%0h exp=0", tx_tag); end
    total++; if (tx_addr !== 64'h1000) begin bad++; $display("FAIL wr_addr got=%0h exp=1000", tx_addr); end
    total++; if (tx_data !== 128'hAABBCCDD) begin bad++; $display("FAIL wr_data got=%0h exp=aabbccdd", tx_data); end
    total++; if (tx_length !== 11'd1) begin bad++; $display("FAIL wr_len got=%0d exp=1", tx_length); end
    tick(3);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL wr_wait_start got=%0h exp=0", tx_start); end
    total++; if (tx_addr !== 64'h1000 || tx_type !== 3'b001 || tx_data !== 128'hAABBCCDD) begin bad++; $display("FAIL wr_hold got=%0h/%0h exp=1000/1", tx_addr, tx_type); end
    total++; if (rd_outstanding !== 9'd0) begin bad++; $display("FAIL wr_rd_out got=%0d exp=0", rd_outstanding); end
    hold_done = 1'b0;
    tick(6);
    total++; if (q1.size() != 1) begin bad++; $display("FAIL wr_single_pulse got=%0d exp=1", q1.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    push(3'b001, 64'h10, 128'h1, 11'd0, ok);
    push(3'b011, 64'hFFFF_0000_0000_0020, 128'h2, 11'h7FF, ok);
    wait_q(1, 2, ok);
    tick(4);
    total++; if (!ok) begin bad++; $display("FAIL b2b_issue got=%0d exp=2", q1.size()); end
    total++; if (q1[1].c - q1[0].c != 3) begin bad++; $display("FAIL b2b_gap got=%0d exp=3", q1[1].c - q1[0].c); end
    total++; if (done_q.size() < 1 || q1[1].c - done_q[0] != 2) begin bad++; $display("FAIL b2b_done_to_start got=%0d exp=2", q1[1].c - done_q[0]); end
    total++; if (q1[0].len !== 11'd0) begin bad++; $display("FAIL b2b_len0 got=%0d exp=0", q1[0].len); end
    total++; if (q1[1].len !== 11'h7FF || q1[1].typ !== 3'b011 || q1[1].addr !== 64'hFFFF_0000_0000_0020) begin bad++; $display("FAIL b2b_wr64 got=%0h/%0h/%0h exp=7ff/3/ffff000000000020", q1[1].len, q1[1].typ, q1[1].addr); end
  endtask

  task automatic test_reads();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) push(3'b010, 64'h1_0000_0000 + 64'(i * 64), '0, 11'd4, ok);
    tick(12);
    total++; if (q1.size() != 3) begin bad++; $display("FAIL rd_count got=%0d exp=3", q1.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (q1[i].tag !== 8'(i) || q1[i].typ !== 3'b010 || q1[i].addr !== 64'h1_0000_0000 + 64'(i * 64)) begin bad++; $display("FAIL rd_tag%0d got=%0h/%0h exp=%0h", i, q1[i].tag, q1[i].addr, i); end
    end
    total++; if (rd_outstanding !== 9'd3) begin bad++; $display("FAIL rd_out3 got=%0d exp=3", rd_outstanding); end
    cpl(8'd1);
    total++; if (rd_outstanding !== 9'd2) begin bad++; $display("FAIL rd_release got=%0d exp=2", rd_outstanding); end
    total++; if (err_spur_cpl !== 1'b0) begin bad++; $display("FAIL rd_no_spur got=%0h exp=0", err_spur_cpl); end
    push(3'b000, 64'h3000, '0, 11'd1, ok);
    tick(8);
    total++; if (q1[3].tag !== 8'd1) begin bad++; $display("FAIL rd_reuse_tag got=%0d exp=1", q1[3].tag); end
    push(3'b010, 64'h4000, '0, 11'd1, ok);
    cpl(8'd0);
    total++; if (rd_outstanding !== 9'd3) begin bad++; $display("FAIL rd_same_cycle got=%0d exp=3", rd_outstanding); end
    tick(8);
    total++; if (q1[4].tag !== 8'd3) begin bad++; $display("FAIL rd_same_cycle_tag got=%0d exp=3", q1[4].tag); end
    push(3'b010, 64'h5000, '0, 11'd1, ok);
    tick(8);
    total++; if (q1[5].tag !== 8'd0 || rd_outstanding !== 9'd4) begin bad++; $display("FAIL rd_freed0 got=%0d/%0d exp=0/4", q1[5].tag, rd_outstanding); end
  endtask

  task automatic test_tag_limit();
    bit ok;
    do_reset();
    push(3'b010, 64'hA0, '0, 11'd1, ok);
    push(3'b010, 64'hA1, '0, 11'd1, ok);
    push(3'b010, 64'hA2, '0, 11'd1, ok);
    push(3'b001, 64'hA3, 128'h33, 11'd1, ok);
    tick(15);
    total++; if (q2.size() != 2) begin bad++; $display("FAIL tl_stall got=%0d exp=2", q2.size()); end
    total++; if (q2[0].tag !== 8'd0 || q2[1].tag !== 8'd1 || q2[1].addr !== 64'hA1) begin bad++; $display("FAIL tl_tags got=%0d/%0d exp=0/1", q2[0].tag, q2[1].tag); end
    total++; if (rd_outstanding_b !== 9'd2) begin bad++; $display("FAIL tl_rd_out got=%0d exp=2", rd_outstanding_b); end
    cpl(8'd0);
    tick(15);
    total++; if (q2.size() != 4) begin bad++; $display("FAIL tl_drain got=%0d exp=4", q2.size()); end
    total++; if (q2[2].tag !== 8'd0 || q2[2].addr !== 64'hA2 || q2[2].typ !== 3'b010) begin bad++; $display("FAIL tl_third_rd got=%0d/%0h exp=0/a2", q2[2].tag, q2[2].addr); end
    total++; if (q2[3].addr !== 64'hA3 || q2[3].typ !== 3'b001 || q2[3].tag !== 8'd0) begin bad++; $display("FAIL tl_write got=%0h/%0h exp=a3/1", q2[3].addr, q2[3].typ); end
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    hold_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%0h exp=1", i, req_ready); end
      push(3'b001, 64'h100 + 64'(i), 128'(i), 11'd2, ok);
    end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready got=%0h exp=0", req_ready); end
    req_type = 3'b001; req_addr = 64'h105; req_data = 128'd5; req_valid = 1'b1;
    tick(3);
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0 || q1.size() != 1) begin bad++; $display("FAIL full_hold got=%0h/%0d exp=0/1", req_ready, q1.size()); end
    hold_done = 1'b0;
    push(3'b001, 64'h105, 128'd5, 11'd2, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_sixth got=timeout exp=accepted"); end
    wait_q(1, 6, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_drain got=%0d exp=6", q1.size()); end
    for (int i = 0; i < 6; i++) begin
      total++; if (q1[i].addr !== 64'h100 + 64'(i) || q1[i].data !== 128'(i)) begin bad++; $display("FAIL full_order%0d got=%0h exp=%0h", i, q1[i].addr, 64'h100 + 64'(i)); end
    end
  endtask

  task automatic test_unsup();
    bit ok;
    do_reset();
    push(3'b101, 64'hDEAD, '0, 11'd1, ok);
    push(3'b000, 64'h2000, '0, 11'd1, ok);
    total++; if (err_unsup !== 1'b1 || tx_start !== 1'b0) begin bad++; $display("FAIL us_pulse got=%0h/%0h exp=1/0", err_unsup, tx_start); end
    tick();
    total++; if (err_unsup !== 1'b0) begin bad++; $display("FAIL us_one_cycle got=%0h exp=0", err_unsup); end
    tick(8);
    total++; if (q1.size() != 1 || q1[0].typ !== 3'b000 || q1[0].tag !== 8'd0 || q1[0].addr !== 64'h2000) begin bad++; $display("FAIL us_read got=%0d/%0h exp=1/2000", q1.size(), q1[0].addr); end
    cpl(8'd7);
    total++; if (err_spur_cpl !== 1'b1 || rd_outstanding !== 9'd1) begin bad++; $display("FAIL us_spur_free got=%0h/%0d exp=1/1", err_spur_cpl, rd_outstanding); end
    tick();
    total++; if (err_spur_cpl !== 1'b0) begin bad++; $display("FAIL us_spur_len got=%0h exp=0", err_spur_cpl); end
    cpl(8'd200);
    total++; if (err_spur_cpl !== 1'b1) begin bad++; $display("FAIL us_spur_range got=%0h exp=1", err_spur_cpl); end
    cpl(8'd0);
    total++; if (err_spur_cpl !== 1'b0 || rd_outstanding !== 9'd0) begin bad++; $display("FAIL us_valid_cpl got=%0h/%0d exp=0/0", err_spur_cpl, rd_outstanding); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    hold_done = 1'b1;
    push(3'b000, 64'h500, '0, 11'd1, ok);
    push(3'b001, 64'h600, '0, 11'd1, ok);
    push(3'b001, 64'h700, '0, 11'd1, ok);
    tick(2);
    total++; if (q1.size() != 1 || rd_outstanding !== 9'd1 || tx_addr !== 64'h500) begin bad++; $display("FAIL rm_pre got=%0d/%0d/%0h exp=1/1/500", q1.size(), rd_outstanding, tx_addr); end
    reset_n = 1'b0;
    #1;
    total++; if (tx_addr !== 64'h0 || tx_type !== 3'b0 || tx_start !== 1'b0 || rd_outstanding !== 9'd0) begin bad++; $display("FAIL rm_async got=%0h/%0h/%0d exp=0/0/0", tx_addr, tx_type, rd_outstanding); end
    tick(2);
    reset_n = 1'b1;
    hold_done = 1'b0;
    tick(12);
    total++; if (q1.size() != 1) begin bad++; $display("FAIL rm_no_start got=%0d exp=1", q1.size()); end
    total++; if (rd_outstanding !== 9'd0 || req_ready !== 1'b1) begin bad++; $display("FAIL rm_post got=%0d/%0h exp=0/1", rd_outstanding, req_ready); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_reads();
    test_tag_limit();
    test_full();
    test_unsup();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/user_tlp_req_ctrl.md
USER_TLP_REQ_CTRL -- requirements
Module: user_tlp_req_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-002 Parameter NUM_TAGS, default 32, read tags available (tags 0..NUM_TAGS-1, <=256).
REQ-003 user_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  upstream request valid.
REQ-006 req_ready  out  1  request FIFO not full.
REQ-007 req_type  in  3  000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64, others unsupported.
REQ-008 req_addr  in  64 / req_data  in  128 / req_length  in  11  request address, write payload, DW count.
REQ-009 tx_type  out  3 / tx_tag  out  8 / tx_addr  out  64 / tx_data  out  128 / tx_length  out  11  fields to the TLP encoder, registered.
REQ-010 tx_start  out  1  one-cycle issue pulse to the encoder.
REQ-011 tx_done  in  1  encoder completion pulse.
REQ-012 cpl_valid  in  1 / cpl_tag  in  8  completion received; releases tag cpl_tag.
REQ-013 rd_outstanding  out  9  count of allocated read tags.
REQ-014 err_unsup  out  1  one-cycle pulse when an unsupported request is discarded.
REQ-015 err_spur_cpl  out  1  one-cycle pulse when cpl_valid names a free or out-of-range tag.

Function
REQ-016 FIFO push when req_valid & req_ready; req_ready = not full; entries leave in arrival order.
REQ-017 FSM states IDLE, ISSUE, WAIT; one request in flight to the encoder at a time.
REQ-018 IDLE, FIFO non-empty, head supported write -> load tx_* from head, tx_tag=8'h00, pop, go ISSUE.
REQ-019 IDLE, FIFO non-empty, head supported read, free tag exists -> load tx_*, tx_tag = lowest free tag index, mark busy, pop, go ISSUE.
REQ-020 IDLE, head read, no free tag -> stay IDLE, no pop (head-of-line blocking; later writes also wait).
REQ-021 IDLE, head unsupported type -> pop, pulse err_unsup, stay IDLE, no tx_start.
REQ-022 ISSUE: tx_start=1 for exactly this cycle; unconditional -> WAIT.
REQ-023 WAIT: tx_* held stable; on tx_done -> IDLE; earliest next tx_start is 2 cycles after tx_done.
REQ-024 tx_start never asserted outside ISSUE; tx_done outside WAIT ignored.
REQ-025 cpl_valid with busy tag < NUM_TAGS: tag freed next cycle; otherwise err_spur_cpl pulse, no state change.
REQ-026 Same-cycle allocation and release: both applied; rd_outstanding = previous +1 -1 (unchanged).
REQ-027 A tag released in cycle N is allocatable from cycle N+1.
REQ-028 tx_addr, tx_data, tx_length, tx_type passed unmodified from the FIFO entry; length 0 passed as-is.
REQ-029 Simultaneous push and pop: both occur; occupancy unchanged.

Reset
REQ-030 reset_n low asynchronously: FSM IDLE, FIFO empty, all tags free, tx_start=0, err_unsup=0, err_spur_cpl=0, rd_outstanding=0, tx_* = 0, req_ready=1 after release.
REQ-031 Reset mid-transaction abandons in-flight request and all queued entries; no tx_start follows release until a new push.

Verification
REQ-032 Push MemWr32 addr 0x1000, data 0xAABBCCDD, len 1 -> tx_start 1 cycle, tx_type 001, tx_tag 0x00, fields held until tx_done, rd_outstanding stays 0.
REQ-033 Push 3 MemRd64, no completions -> tags 0,1,2 in order, rd_outstanding 3; cpl_tag 1 then new read -> tag 1.
REQ-034 NUM_TAGS=2, push Rd, Rd, Rd, Wr -> two reads issue, third read and write stall; cpl_tag 0 -> third read issues tag 0, then write.
REQ-035 Push FIFO_DEPTH+1 requests while encoder withholds tx_done -> req_ready low at full, no loss, strict order on drain.
REQ-036 Push type 101 then MemRd32 -> err_unsup pulse, no tx_start for it, read issues with tag 0; cpl_tag 7 (free) -> err_spur_cpl pulse.
REQ-037 Assert reset_n low during WAIT with 2 entries queued -> outputs reset immediately, no tx_start after release, rd_outstanding 0.
